// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_unit_if;
    logic        id_stall;
    logic        br_redirect;
    logic [15:0] br_target;
    logic        im_rdy;
    logic [15:0] im_data;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr_IF;
    logic [15:0] pc_plus1_IF;
    logic        if_bubble;
    logic        halted;
    logic [15:0] fetch_cnt;

    modport master (
        input  id_stall, br_redirect, br_target, im_rdy, im_data,
        output im_addr, im_rd_en, im_instr_IF, pc_plus1_IF, if_bubble, halted, fetch_cnt
    );

    modport slave (
        output id_stall, br_redirect, br_target, im_rdy, im_data,
        input  im_addr, im_rd_en, im_instr_IF, pc_plus1_IF, if_bubble, halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives IF/ID combinationally (zero-cycle fetch).
// Stall replays the last output; miss/halt/redirect insert NOP bubbles.
module fetch_unit #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master fif
);
    typedef enum logic [1:0] {RUN, MISS, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] last_instr_q, last_pp1_q;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic        halted_q;

    logic [15:0] instr;
    logic [15:0] pp1;
    logic        bubble;
    logic        rd_en;
    logic [15:0] pc_inc;

    assign pc_inc = pc_q + 16'd1;

    always_comb begin
        instr       = NOP_INSTR;
        pp1         = 16'h0000;
        bubble      = 1'b1;
        rd_en       = 1'b0;
        pc_d        = pc_q;
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        if (fif.br_redirect) begin
            pc_d    = fif.br_target;
            state_d = RUN;
        end else if (fif.id_stall) begin
            instr  = last_instr_q;
            pp1    = last_pp1_q;
            bubble = 1'b0;
        end else if (state_q == HALTED) begin
            // bubble defaults already apply; only redirect or reset exits
        end else if (!fif.im_rdy) begin
            rd_en   = 1'b1;
            state_d = MISS;
        end else begin
            rd_en  = 1'b1;
            instr  = fif.im_data;
            pp1    = pc_inc;
            bubble = 1'b0;
            if (fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
            // HLT is delivered once; PC parks on it so a later redirect is the only way on
            if (fif.im_data[15:12] == HLT_OPCODE) begin
                state_d = HALTED;
            end else begin
                pc_d    = pc_inc;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= PC_RESET;
            last_instr_q <= NOP_INSTR;
            last_pp1_q   <= 16'h0000;
            fetch_cnt_q  <= 16'h0000;
            halted_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            halted_q    <= (state_d == HALTED);
            // Redirect overrides a concurrent stall, so its bubble is captured too
            if (!fif.id_stall || fif.br_redirect) begin
                last_instr_q <= instr;
                last_pp1_q   <= pp1;
            end
        end
    end

    assign fif.im_addr     = pc_q;
    assign fif.im_rd_en    = rd_en;
    assign fif.im_instr_IF = instr;
    assign fif.pc_plus1_IF = pp1;
    assign fif.if_bubble   = bubble;
    assign fif.halted      = halted_q;
    assign fif.fetch_cnt   = fetch_cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Vector-table bench for fetch_unit with a scoreboard queue of expected outputs.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    fetch_unit_if fif ();

    fetch_unit #(
        .PC_RESET   (16'h0000),
        .NOP_INSTR  (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] data;
        logic [15:0] addr;
        logic        rd;
        logic [15:0] instr;
        logic [15:0] pp1;
        logic        bub;
        logic        halt;
        logic [15:0] cnt;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[28];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(logic stall, logic redir, logic [15:0] tgt, logic rdy,
                                logic [15:0] data, logic [15:0] addr, logic rd,
                                logic [15:0] instr, logic [15:0] pp1, logic bub,
                                logic halt, logic [15:0] cnt);
        vec_t v;
        v.stall = stall; v.redir = redir; v.tgt = tgt; v.rdy = rdy; v.data = data;
        v.addr = addr; v.rd = rd; v.instr = instr; v.pp1 = pp1; v.bub = bub;
        v.halt = halt; v.cnt = cnt;
        return v;
    endfunction

    // Drive at posedge+1, compare at the following negedge, return at next posedge+1.
    task automatic run_vec(input string name, input vec_t v);
        vec_t e;
        fif.id_stall    = v.stall;
        fif.br_redirect = v.redir;
        fif.br_target   = v.tgt;
        fif.im_rdy      = v.rdy;
        fif.im_data     = v.data;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        n_vec++;
        if (fif.im_addr !== e.addr || fif.im_rd_en !== e.rd || fif.im_instr_IF !== e.instr ||
            fif.pc_plus1_IF !== e.pp1 || fif.if_bubble !== e.bub || fif.halted !== e.halt ||
            fif.fetch_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s: got addr=%h rd=%b instr=%h pp1=%h bub=%b halt=%b cnt=%h, want addr=%h rd=%b instr=%h pp1=%h bub=%b halt=%b cnt=%h",
                     name, fif.im_addr, fif.im_rd_en, fif.im_instr_IF, fif.pc_plus1_IF,
                     fif.if_bubble, fif.halted, fif.fetch_cnt,
                     e.addr, e.rd, e.instr, e.pp1, e.bub, e.halt, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t rst_v;

    initial begin
        n_vec = 0;
        n_err = 0;
        //           stall redir tgt      rdy data      addr     rd instr     pp1      bub hlt cnt
        vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 1, 16'h1234, 16'h0001, 0, 0, 16'd0);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h5678, 16'h0001, 1, 16'h5678, 16'h0002, 0, 0, 16'd1);
        vecs[2]  = mk(0, 0, 16'h0000, 1, 16'h0AAA, 16'h0002, 1, 16'h0AAA, 16'h0003, 0, 0, 16'd2);
        vecs[3]  = mk(0, 0, 16'h0000, 1, 16'h0BBB, 16'h0003, 1, 16'h0BBB, 16'h0004, 0, 0, 16'd3);
        vecs[4]  = mk(0, 0, 16'h0000, 1, 16'hA111, 16'h0004, 1, 16'hA111, 16'h0005, 0, 0, 16'd4);
        vecs[5]  = mk(1, 0, 16'h0000, 1, 16'h0CCC, 16'h0005, 0, 16'hA111, 16'h0005, 0, 0, 16'd5);
        vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0005, 0, 16'hA111, 16'h0005, 0, 0, 16'd5);
        vecs[7]  = mk(0, 0, 16'h0000, 1, 16'h0DDD, 16'h0005, 1, 16'h0DDD, 16'h0006, 0, 0, 16'd5);
        vecs[8]  = mk(0, 1, 16'h0010, 1, 16'h0EEE, 16'h0006, 0, 16'h0000, 16'h0000, 1, 0, 16'd6);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0000, 16'h0000, 1, 0, 16'd6);
        vecs[10] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0000, 16'h0000, 1, 0, 16'd6);
        vecs[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 16'h0000, 16'h0000, 1, 0, 16'd6);
        vecs[12] = mk(0, 0, 16'h0000, 1, 16'h2222, 16'h0010, 1, 16'h2222, 16'h0011, 0, 0, 16'd6);
        vecs[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0011, 1, 16'h0000, 16'h0000, 1, 0, 16'd7);
        vecs[14] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0011, 0, 16'h0000, 16'h0000, 0, 0, 16'd7);
        vecs[15] = mk(0, 1, 16'h0040, 0, 16'h0000, 16'h0011, 0, 16'h0000, 16'h0000, 1, 0, 16'd7);
        vecs[16] = mk(0, 0, 16'h0000, 1, 16'h0123, 16'h0040, 1, 16'h0123, 16'h0041, 0, 0, 16'd7);
        vecs[17] = mk(0, 1, 16'h0020, 0, 16'h0000, 16'h0041, 0, 16'h0000, 16'h0000, 1, 0, 16'd8);
        vecs[18] = mk(0, 0, 16'h0000, 1, 16'hF000, 16'h0020, 1, 16'hF000, 16'h0021, 0, 0, 16'd8);
        vecs[19] = mk(0, 0, 16'h0000, 1, 16'h0555, 16'h0020, 0, 16'h0000, 16'h0000, 1, 1, 16'd9);
        vecs[20] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0020, 0, 16'h0000, 16'h0000, 1, 1, 16'd9);
        vecs[21] = mk(1, 0, 16'h0000, 1, 16'h0666, 16'h0020, 0, 16'h0000, 16'h0000, 0, 1, 16'd9);
        vecs[22] = mk(0, 1, 16'h0030, 1, 16'h0777, 16'h0020, 0, 16'h0000, 16'h0000, 1, 1, 16'd9);
        vecs[23] = mk(0, 0, 16'h0000, 1, 16'h0888, 16'h0030, 1, 16'h0888, 16'h0031, 0, 0, 16'd9);
        vecs[24] = mk(1, 1, 16'h0050, 1, 16'h0111, 16'h0031, 0, 16'h0000, 16'h0000, 1, 0, 16'd10);
        vecs[25] = mk(0, 0, 16'h0000, 1, 16'h0999, 16'h0050, 1, 16'h0999, 16'h0051, 0, 0, 16'd10);
        vecs[26] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0051, 1, 16'h0000, 16'h0000, 1, 0, 16'd11);
        vecs[27] = mk(0, 0, 16'h0000, 1, 16'hF123, 16'h0051, 1, 16'hF123, 16'h0052, 0, 0, 16'd11);
        rst_v    = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 1, 0, 16'd0);

        rst_n           = 1'b0;
        fif.id_stall    = 1'b0;
        fif.br_redirect = 1'b0;
        fif.br_target   = 16'h0000;
        fif.im_rdy      = 1'b0;
        fif.im_data     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        run_vec("reset", rst_v);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while halted, then reset while missing.
        run_vec("halted_hold", mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0051, 0, 16'h0000, 16'h0000, 1, 1, 16'd12));
        rst_n = 1'b0;
        run_vec("reset_mid_halt", rst_v);
        rst_n = 1'b1;
        run_vec("miss_after_rst", mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 1, 0, 16'd0));
        rst_n = 1'b0;
        run_vec("reset_mid_miss", rst_v);
        rst_n = 1'b1;
        run_vec("fetch_after_rst", mk(0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 1, 16'h1234, 16'h0001, 0, 0, 16'd0));

        // Walk the PC up to FFFF so the wrap and counter saturation meet.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        fif.im_rdy  = 1'b1;
        fif.im_data = 16'h1000;
        repeat (65535) @(posedge clk);
        #1;
        run_vec("pc_wrap", mk(0, 0, 16'h0000, 1, 16'h3333, 16'hFFFF, 1, 16'h3333, 16'h0000, 0, 0, 16'hFFFF));
        run_vec("cnt_sat", mk(0, 0, 16'h0000, 1, 16'h4444, 16'h0000, 1, 16'h4444, 16'h0001, 0, 0, 16'hFFFF));
        run_vec("cnt_sat2", mk(0, 0, 16'h0000, 1, 16'h5555, 16'h0001, 1, 16'h5555, 16'h0002, 0, 0, 16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 16-bit 5-stage pipeline. It sits directly upstream of the IF/ID pipe register and drives that register's instruction and PC+1 inputs every cycle.
- Owns the PC register and the instruction-memory read port.
- Handles ID-stage stalls, MEM-stage branch redirects, multi-cycle instruction-memory misses and HLT detection.
- The IF/ID register has no enable, so this block implements a stall by replaying its previous output.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0000, bubble instruction (ADD R0,R0,R0) driven on flush, miss or halt.
HLT_OPCODE, 4'hF, opcode in instr[15:12] that triggers the halt sequence.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset; asynchronous, active-low.
id_stall  input  1  hazard unit: IF/ID contents must be held this cycle.
br_redirect  input  1  MEM stage: taken branch/JAL/JR, flush and redirect.
br_target  input  16  redirect target PC.
im_rdy  input  1  instruction memory: im_data is valid for im_addr this cycle.
im_data  input  16  instruction read data.
im_addr  output  16  fetch address; always equals the PC register.
im_rd_en  output  1  read request.
im_instr_IF  output  16  instruction to the IF/ID pipe.
pc_plus1_IF  output  16  PC+1 to the IF/ID pipe.
if_bubble  output  1  high when im_instr_IF is an inserted NOP_INSTR.
halted  output  1  high in state HALTED.
fetch_cnt  output  16  count of instructions delivered; saturates at 16'hFFFF.

Behaviour:
Registers:
- pc
- state ∈ {RUN, MISS, HALTED}
- last_instr, last_pp1 (replay copy of the previous cycle's outputs)
- fetch_cnt

Reset (async, while rst_n=0):
- pc=PC_RESET, state=RUN, last_instr=NOP_INSTR, last_pp1=0, fetch_cnt=0.
- Outputs therefore read: im_addr=PC_RESET, im_rd_en=1, halted=0, fetch_cnt=0.
- im_instr_IF, pc_plus1_IF and if_bubble follow the combinational rules below with state=RUN.

Output priority, highest first, evaluated combinationally each cycle:
1. br_redirect=1:
   - Outputs: instr=NOP_INSTR, pp1=0, if_bubble=1.
   - Next: pc<=br_target, state<=RUN.
   - Applies in every state and overrides id_stall and any pending miss.
2. id_stall=1:
   - Outputs: instr=last_instr, pp1=last_pp1, if_bubble=0.
   - pc, state and fetch_cnt hold; im_rd_en=0.
   - An im_rdy pulse this cycle is ignored and the fetch is reissued later.
3. state=HALTED:
   - Outputs: instr=NOP_INSTR, pp1=0, if_bubble=1, im_rd_en=0.
   - pc frozen. Only a redirect or reset leaves HALTED.
4. im_rdy=0 (RUN or MISS):
   - Outputs: instr=NOP_INSTR, pp1=0, if_bubble=1.
   - pc holds, im_rd_en=1, state<=MISS.
5. im_rdy=1 (RUN or MISS):
   - Outputs: instr=im_data, pp1=pc+1 (16-bit, 16'hFFFF+1 wraps to 16'h0000), if_bubble=0.
   - pc<=pc+1; fetch_cnt increments, saturating at 16'hFFFF.
   - If im_data[15:12]==HLT_OPCODE: state<=HALTED and pc holds instead of incrementing. The HLT itself is delivered exactly once.
   - Otherwise state<=RUN.

Replay copy update:
- On every rising edge except under id_stall: last_instr<=im_instr_IF, last_pp1<=pc_plus1_IF.
- Bubbles are captured too, so a stall following a bubble replays the bubble.

Latency and signal rules:
- Zero-cycle fetch: the instruction is presented in the same cycle im_rdy is high and latched into IF/ID at the following edge.
- Redirect-to-first-fetch is 1 cycle.
- im_rd_en=1 in RUN/MISS when neither id_stall nor br_redirect is active.
- halted = (state==HALTED), registered.

Reset mid-miss or mid-halt: returns to RUN at PC_RESET immediately; no partial state survives.

Test Plan:
1. Reset, then im_rdy=1 with im_data=16'h1234, 16'h5678 -> cycle 0 outputs 1234/pp1=0001, cycle 1 outputs 5678/pp1=0002; im_addr 0000→0001→0002; fetch_cnt=2.
2. Fetch 16'hA111 at PC 0004, then id_stall=1 for 2 cycles -> outputs stay A111/0005, im_addr stays 0005, fetch_cnt unchanged; after release, the next fetch is at 0005.
3. im_rdy=0 for 3 cycles at PC 0010 -> 3 bubbles (0000, if_bubble=1), im_addr=0010 throughout; 4th cycle im_rdy=1 with 16'h2222 -> output 2222/0011.
4. During MISS, br_redirect=1 with br_target=16'h0040 -> bubble that cycle; next cycle im_addr=0040, state RUN.
5. Fetch 16'hF000 at PC 0020 -> HLT output once with pp1=0021; afterwards halted=1, im_rd_en=0, NOPs; br_redirect to 0030 -> halted=0 and fetch resumes at 0030.
6. PC=FFFF fetching 16'h3333 -> pp1=0000 and next im_addr=0000; also assert id_stall and br_redirect together -> redirect wins.
